// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: fixed-latency read/write access to a word array,
// with a pipeline stall while the access is pending.
module data_mem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned BASE_ADDR = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] memory_data,
    output logic        stall,
    output logic        ready,
    output logic        addr_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic        write_q;
    logic        err_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH];

    logic          req;
    logic [31:0]   off_d;
    logic          err_d;
    logic [AW-1:0] idx_d;
    logic          complete;

    // Range check on the byte offset is equivalent to idx >= DEPTH.
    always_comb begin
        req      = mem_r_en | mem_w_en;
        off_d    = address - BASE_ADDR;
        err_d    = (address[1:0] != 2'b00) || (address < BASE_ADDR) || (off_d >= DEPTH * 4);
        idx_d    = off_d[AW+1:2];
        complete = (state_q == BUSY) && (count_q == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        write_q <= mem_w_en;
                        err_q   <= err_d;
                        idx_q   <= idx_d;
                        wdata_q <= write_data;
                        count_q <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_q != '0) begin
                        count_q <= count_q - 4'd1;
                    end else begin
                        if (!write_q) rdata_q <= err_q ? '0 : mem_q[idx_q];
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array has no reset; reset forces IDLE asynchronously, so no pending write can commit.
    always_ff @(posedge clock) begin
        if (complete && write_q && !err_q) mem_q[idx_q] <= wdata_q;
    end

    assign stall       = !reset && (((state_q == IDLE) && req) || (state_q == BUSY));
    assign ready       = (state_q == DONE);
    assign addr_error  = (state_q == DONE) && err_q;
    assign memory_data = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned BASE_ADDR = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data;
    logic [31:0] memory_data;
    logic        stall, ready, addr_error;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rd;

    data_mem_responder #(
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .write_data (write_data),
        .memory_data(memory_data),
        .stall      (stall),
        .ready      (ready),
        .addr_error (addr_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        if (a % 4 != 0) return 1'b1;
        if (a < BASE_ADDR) return 1'b1;
        return ((a - BASE_ADDR) / 4) >= DEPTH;
    endfunction

    // Called 1ns after a rising edge with the DUT idle; returns at the same phase, DUT idle.
    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        bit          bad;
        int unsigned idx;
        int unsigned nstall;
        bad    = addr_bad(a);
        idx    = (a - BASE_ADDR) / 4;
        nstall = 0;
        mem_w_en = we; mem_r_en = re; address = a; write_data = wd;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (ready) break;
            if (stall) nstall++;
            @(posedge clock); #1;
        end
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".stall_cycles"}, nstall, LATENCY + 1);
        if (we) begin
            if (!bad) mdl_mem[idx] = wd;
        end else begin
            mdl_rd = bad ? 32'd0 : mdl_mem[idx];
        end
        check({tag, ".data"}, memory_data, mdl_rd);
        check({tag, ".addr_error"}, 32'(addr_error), 32'(bad));
        check({tag, ".stall_done"}, 32'(stall), 32'd0);
        // Inputs remain held through DONE; the served request must not be re-accepted.
        @(posedge clock); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        #1;
        check({tag, ".idle_after"}, {30'd0, stall, ready}, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] bad_addrs [6];
        logic [31:0] a;
        int unsigned kind;
        bad_addrs = '{32'd1026, 32'd1280, 32'd1020, 32'd0, 32'd1025, 32'hFFFF_FFFC};
        mdl_rd = '0;
        reset = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; write_data = '0;
        #3;
        check("reset.data", memory_data, 32'd0);
        check("reset.flags", {29'd0, stall, ready, addr_error}, 32'd0);
        #9 reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < int'(DEPTH); i++)
            access(1'b1, 1'b0, BASE_ADDR + 32'(i) * 4, $urandom, "preload");

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "t1w");
        access(1'b0, 1'b1, 32'd1024, 32'h0, "t1r");
        check("t1.value", memory_data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'h11111111, "t2w0");
        access(1'b1, 1'b0, 32'd1032, 32'h22222222, "t2w1");
        access(1'b0, 1'b1, 32'd1032, 32'h0, "t2r0");
        access(1'b0, 1'b1, 32'd1028, 32'h0, "t2r1");
        access(1'b1, 1'b0, 32'd1026, 32'hCAFEF00D, "t3w");
        access(1'b0, 1'b1, 32'd1024, 32'h0, "t3r");
        access(1'b0, 1'b1, 32'd1280, 32'h0, "t4r0");
        access(1'b0, 1'b1, 32'd1020, 32'h0, "t4r1");
        access(1'b1, 1'b0, 32'd1036, 32'hAAAAAAAA, "t5w");

        // Reset during the second BUSY cycle of a write.
        mem_w_en = 1'b1; address = 32'd1036; write_data = 32'h12345678;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("t5.rst_stall", 32'(stall), 32'd0);
        check("t5.rst_data", memory_data, 32'd0);
        mdl_rd = '0;
        @(posedge clock); #1;
        reset = 1'b0; mem_w_en = 1'b0;
        @(posedge clock); #1;
        access(1'b0, 1'b1, 32'd1036, 32'h0, "t5r");
        check("t5.value", memory_data, 32'hAAAAAAAA);

        access(1'b1, 1'b1, 32'd1040, 32'h5A5A5A5A, "t6both");
        access(1'b0, 1'b1, 32'd1040, 32'h0, "t6r");

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = bad_addrs[$urandom_range(0, 5)];
            else a = BASE_ADDR + 4 * $urandom_range(0, DEPTH - 1);
            access(kind != 2, kind >= 2, a, $urandom, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
